// File: rtl/inta_sequencer.sv
// inta_sequencer: 8259 interrupt-acknowledge sequencer (INTA pulse counting, ISR strobes, cascade and vector drive)
module inta_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [7:0] highest_ir,
    input  logic [2:0] icw1_a,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic       upm,
    input  logic       aeoi,
    input  logic       sngl,
    input  logic       sp_en,
    input  logic [2:0] cas_in,
    output logic       irq,
    output logic       freeze,
    output logic [2:0] cas_out,
    output logic       cas_oe,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] isr_set,
    output logic [7:0] isr_clr,
    output logic       ack_done,
    output logic       ack_err
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, PULSE1, GAP1, PULSE2, GAP2, PULSE3} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic prev, fall, rise, fin, spur, spur_nx, resp, resp_q, resp_nx, cas, p1_oe;
    logic [7:0] ir, ir_nx, lat_ir;
    logic [2:0] idx;
    logic [CW-1:0] cnt, cnt_nx;
    logic irq_nx, freeze_nx, cas_oe_nx, data_oe_nx, done_nx, err_nx;
    logic [2:0] cas_out_nx;
    logic [7:0] data_out_nx, isr_set_nx, isr_clr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], inta_n};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign fall = prev & ~sync[SYNC_STAGES-1];
    assign rise = ~prev & sync[SYNC_STAGES-1];

    // In IDLE the IR about to be latched drives idx so PULSE1 entry sees its own vector
    always_comb begin
        lat_ir = (state == IDLE) ? ((highest_ir == 8'h00) ? 8'h80 : highest_ir) : ir;
        idx = {|(lat_ir & 8'hF0), |(lat_ir & 8'hCC), |(lat_ir & 8'hAA)};
        resp = sngl | (sp_en & ~icw3[idx]) | (~sp_en & (cas_in == icw3[2:0]));
        cas = sp_en & ~sngl & icw3[idx];
        p1_oe = ~upm & (sngl | sp_en) & resp;
    end

    always_comb begin
        state_nx = state;
        ir_nx = ir;
        spur_nx = spur;
        resp_nx = resp_q;
        cnt_nx = cnt;
        irq_nx = irq;
        freeze_nx = freeze;
        cas_out_nx = cas_out;
        cas_oe_nx = cas_oe;
        data_out_nx = data_out;
        data_oe_nx = data_oe;
        isr_set_nx = '0;
        isr_clr_nx = '0;
        done_nx = 1'b0;
        err_nx = 1'b0;
        fin = 1'b0;
        unique case (state)
            IDLE: begin
                irq_nx = int_req;
                if (fall) begin
                    state_nx = PULSE1;
                    ir_nx = lat_ir;
                    spur_nx = (highest_ir == 8'h00);
                    irq_nx = 1'b0;
                    freeze_nx = 1'b1;
                    cas_oe_nx = cas;
                    cas_out_nx = cas ? idx : 3'd0;
                    data_oe_nx = p1_oe;
                    data_out_nx = p1_oe ? 8'hCD : 8'h00;
                end
            end
            PULSE1: if (rise) begin
                state_nx = GAP1;
                resp_nx = resp;
                data_oe_nx = 1'b0;
                data_out_nx = 8'h00;
                cnt_nx = '0;
                isr_set_nx = ((resp | sp_en) & ~spur) ? ir : 8'h00;
            end
            GAP1, GAP2: begin
                if (fall) begin
                    state_nx = (state == GAP1) ? PULSE2 : PULSE3;
                    cnt_nx = '0;
                    data_oe_nx = resp_q;
                    data_out_nx = !resp_q ? 8'h00 : (state == GAP2) ? icw2 :
                                  upm ? {icw2[7:3], idx} : {icw1_a, idx, 2'b00};
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_nx = IDLE;
                    err_nx = 1'b1;
                    freeze_nx = 1'b0;
                    cas_oe_nx = 1'b0;
                    cas_out_nx = 3'd0;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PULSE2: if (rise) begin
                data_oe_nx = 1'b0;
                data_out_nx = 8'h00;
                cnt_nx = '0;
                fin = upm;
                state_nx = upm ? PULSE2 : GAP2;
            end
            PULSE3: fin = rise;
            default: state_nx = IDLE;
        endcase
        if (fin) begin
            state_nx = IDLE;
            done_nx = 1'b1;
            freeze_nx = 1'b0;
            cas_oe_nx = 1'b0;
            cas_out_nx = 3'd0;
            data_oe_nx = 1'b0;
            data_out_nx = 8'h00;
            isr_clr_nx = (aeoi & ~spur) ? ir : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ir <= '0;
            spur <= 1'b0;
            resp_q <= 1'b0;
            cnt <= '0;
            irq <= 1'b0;
            freeze <= 1'b0;
            cas_out <= '0;
            cas_oe <= 1'b0;
            data_out <= '0;
            data_oe <= 1'b0;
            isr_set <= '0;
            isr_clr <= '0;
            ack_done <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state <= state_nx;
            ir <= ir_nx;
            spur <= spur_nx;
            resp_q <= resp_nx;
            cnt <= cnt_nx;
            irq <= irq_nx;
            freeze <= freeze_nx;
            cas_out <= cas_out_nx;
            cas_oe <= cas_oe_nx;
            data_out <= data_out_nx;
            data_oe <= data_oe_nx;
            isr_set <= isr_set_nx;
            isr_clr <= isr_clr_nx;
            ack_done <= done_nx;
            ack_err <= err_nx;
        end
    end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed and randomized acknowledge cycles checked against a behavioural model
module tb_inta_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, inta_n = 1'b1, int_req = 1'b0;
    logic [7:0] highest_ir = '0, icw2 = '0, icw3 = '0;
    logic [2:0] icw1_a = '0, cas_in = '0;
    logic upm = 1'b1, aeoi = 1'b0, sngl = 1'b1, sp_en = 1'b1;
    logic irq, freeze, cas_oe, data_oe, ack_done, ack_err;
    logic [2:0] cas_out;
    logic [7:0] data_out, isr_set, isr_clr;
    int checks = 0, errors = 0;
    int set_cnt = 0, clr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] set_last = '0, clr_last = '0;

    inta_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .int_req(int_req), .highest_ir(highest_ir),
        .icw1_a(icw1_a), .icw2(icw2), .icw3(icw3), .upm(upm), .aeoi(aeoi), .sngl(sngl),
        .sp_en(sp_en), .cas_in(cas_in), .irq(irq), .freeze(freeze), .cas_out(cas_out),
        .cas_oe(cas_oe), .data_out(data_out), .data_oe(data_oe), .isr_set(isr_set),
        .isr_clr(isr_clr), .ack_done(ack_done), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (isr_set != 0) begin
            set_cnt <= set_cnt + 1;
            set_last <= isr_set;
        end
        if (isr_clr != 0) begin
            clr_cnt <= clr_cnt + 1;
            clr_last <= isr_clr;
        end
        if (ack_done) done_cnt <= done_cnt + 1;
        if (ack_err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v);
        @(posedge clk);
        #3 inta_n = v;
        repeat (5) @(negedge clk);
    endtask

    task automatic cfg(input logic u, s, m, a, input logic [2:0] a75, input logic [7:0] base,
                       input logic [7:0] c3, input logic [2:0] ci, input logic [7:0] hir);
        upm = u; sngl = s; sp_en = m; aeoi = a; icw1_a = a75; icw2 = base;
        icw3 = c3; cas_in = ci; highest_ir = hir;
    endtask

    // Full acknowledge cycle; expectations come from the pin-level rules of the 8259
    task automatic do_ack(input string tag);
        int ix, np, s0, c0, d0, e0;
        bit spur, resp, cas;
        bit exp_oe[3];
        logic [7:0] exp_byte[3];
        logic [7:0] exp_set, exp_clr;
        spur = (highest_ir == 0);
        ix = 7;
        for (int i = 0; i < 8; i++) if (highest_ir[i]) ix = i;
        resp = sngl || (sp_en && !icw3[ix]) || (!sp_en && cas_in == icw3[2:0]);
        cas = sp_en && !sngl && icw3[ix];
        np = upm ? 2 : 3;
        exp_oe[0] = !upm && resp && (sngl || sp_en);
        exp_byte[0] = 8'hCD;
        exp_oe[1] = resp;
        exp_byte[1] = upm ? 8'((icw2 & 8'hF8) + ix) : 8'(icw1_a * 32 + ix * 4);
        exp_oe[2] = resp;
        exp_byte[2] = icw2;
        exp_set = ((resp || sp_en) && !spur) ? 8'(1 << ix) : 8'h00;
        exp_clr = (aeoi && !spur) ? highest_ir : 8'h00;
        int_req = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_irq_idle"}, irq, 1);
        s0 = set_cnt; c0 = clr_cnt; d0 = done_cnt; e0 = err_cnt;
        for (int p = 0; p < np; p++) begin
            drive(1'b0);
            chk($sformatf("%s_p%0d_oe", tag, p + 1), data_oe, exp_oe[p]);
            if (exp_oe[p]) chk($sformatf("%s_p%0d_data", tag, p + 1), data_out, exp_byte[p]);
            chk($sformatf("%s_p%0d_cas_oe", tag, p + 1), cas_oe, cas);
            chk($sformatf("%s_p%0d_cas_out", tag, p + 1), cas_out, cas ? ix : 0);
            chk($sformatf("%s_p%0d_freeze", tag, p + 1), freeze, 1);
            chk($sformatf("%s_p%0d_irq", tag, p + 1), irq, 0);
            drive(1'b1);
        end
        chk({tag, "_set_cnt"}, set_cnt - s0, exp_set != 0);
        if (exp_set != 0) chk({tag, "_set_val"}, set_last, exp_set);
        chk({tag, "_clr_cnt"}, clr_cnt - c0, exp_clr != 0);
        if (exp_clr != 0) chk({tag, "_clr_val"}, clr_last, exp_clr);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err_cnt - e0, 0);
        chk({tag, "_end_freeze"}, freeze, 0);
        chk({tag, "_end_cas_oe"}, cas_oe, 0);
        chk({tag, "_end_oe"}, data_oe, 0);
    endtask

    initial begin
        int s0, c0, d0, e0;
        int_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_irq", irq, 0);
        chk("rst_outs", {freeze, cas_oe, cas_out, data_oe, data_out, ack_done, ack_err}, 0);
        chk("rst_isr", {isr_set, isr_clr}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        int_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_irq_low", irq, 0);
        cfg(1, 1, 1, 0, 3'b000, 8'h40, 8'h00, 3'd0, 8'h08);
        do_ack("d8086");
        cfg(0, 1, 1, 0, 3'b101, 8'h12, 8'h00, 3'd0, 8'h04);
        do_ack("d8080");
        cfg(1, 0, 1, 0, 3'b000, 8'h40, 8'h04, 3'd0, 8'h04);
        do_ack("dmaster");
        cfg(1, 0, 0, 0, 3'b000, 8'h40, 8'h02, 3'd2, 8'h01);
        do_ack("dslave_hit");
        cfg(1, 0, 0, 0, 3'b000, 8'h40, 8'h02, 3'd3, 8'h01);
        do_ack("dslave_miss");
        cfg(1, 1, 1, 1, 3'b000, 8'h40, 8'h00, 3'd0, 8'h00);
        do_ack("dspur");
        cfg(0, 1, 1, 1, 3'b011, 8'h9A, 8'h00, 3'd0, 8'h20);
        do_ack("d8080_aeoi");
        for (int n = 0; n < 40; n++) begin
            cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                8'($urandom), 8'($urandom), 3'($urandom),
                ($urandom_range(0, 8) == 8) ? 8'h00 : 8'(1 << $urandom_range(0, 7)));
            do_ack($sformatf("rnd%0d", n));
        end
        // Stall in GAP1 on a cascaded master so the abort must also drop the cascade drive
        cfg(1, 0, 1, 1, 3'b000, 8'h40, 8'h02, 3'd0, 8'h02);
        s0 = set_cnt; c0 = clr_cnt; d0 = done_cnt; e0 = err_cnt;
        drive(1'b0);
        drive(1'b1);
        repeat (1000) @(negedge clk);
        chk("to_early_err", err_cnt - e0, 0);
        chk("to_early_freeze", freeze, 1);
        chk("to_early_cas_oe", cas_oe, 1);
        repeat (100) @(negedge clk);
        chk("to_err", err_cnt - e0, 1);
        chk("to_freeze", freeze, 0);
        chk("to_cas_oe", cas_oe, 0);
        chk("to_done", done_cnt - d0, 0);
        chk("to_clr", clr_cnt - c0, 0);
        chk("to_set", set_cnt - s0, 1);
        cfg(1, 1, 1, 1, 3'b000, 8'h40, 8'h00, 3'd0, 8'h10);
        do_ack("after_to");
        s0 = set_cnt; c0 = clr_cnt; d0 = done_cnt;
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        chk("rst_mid_oe_before", data_oe, 1);
        chk("rst_mid_data_before", data_out, 8'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", data_oe, 0);
        chk("rst_mid_freeze", freeze, 0);
        chk("rst_mid_cas_oe", cas_oe, 0);
        repeat (2) @(negedge clk);
        inta_n = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_done", done_cnt - d0, 0);
        chk("rst_mid_clr", clr_cnt - c0, 0);
        chk("rst_mid_set", set_cnt - s0, 1);
        do_ack("after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
